// File: rtl/muldiv_unit_p.sv
// muldiv_unit_p: HI/LO multiply/divide unit; timed ops hold busy MUL_CYCLES/DIV_CYCLES, then commit with a done pulse.
// No backpressure: the pipeline stalls on start||busy; a start while busy is dropped, cancel kills the op in flight.
module muldiv_unit_p #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int W2   = 2 * WIDTH;

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            busy_q, busy_d, done_q, done_d;

  logic            is_mul, is_div, issue_ok, launch, commit, sgn;
  logic [W2-1:0]   a_ext, b_ext, prod, hl_cur, res_sel;
  logic            a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  // Decode; cancel overrides any start in the same cycle, including mthi/mtlo.
  always_comb begin
    is_mul   = op inside {4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9};
    is_div   = (op == 4'd2) || (op == 4'd3);
    issue_ok = (state_q == IDLE) && start && !cancel;
    launch   = issue_ok && (is_mul || is_div);
    commit   = (state_q == RUN) && !cancel && (cnt_q == CW'(1));
    sgn      = ~op[0];
  end

  // Result is computed at launch from the operands and HI/LO of that cycle, then held until commit.
  always_comb begin
    hl_cur = {hi_q, lo_q};
    a_ext  = {{WIDTH{sgn & rs[WIDTH-1]}}, rs};
    b_ext  = {{WIDTH{sgn & rt[WIDTH-1]}}, rt};
    prod   = a_ext * b_ext;

    a_neg  = sgn & rs[WIDTH-1];
    b_neg  = sgn & rt[WIDTH-1];
    a_mag  = a_neg ? -rs : rs;
    b_mag  = b_neg ? -rt : rt;
    b_safe = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;

    case (op)
      4'd0, 4'd1: res_sel = prod;
      4'd6, 4'd7: res_sel = hl_cur + prod;
      4'd8, 4'd9: res_sel = hl_cur - prod;
      4'd2, 4'd3: res_sel = (rt == '0) ? hl_cur : {rem, quot};
      default:    res_sel = hl_cur;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = RUN;
          cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        end
      end
      RUN: begin
        if (cancel || cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    res_d  = res_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    busy_d = (state_d == RUN);
    if (launch) res_d = res_sel;
    if (commit) begin
      {hi_d, lo_d} = res_q;
      done_d       = 1'b1;
    end
    if (issue_ok && op == 4'd4) hi_d = rs;
    if (issue_ok && op == 4'd5) lo_d = rs;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit_p.sv
// Bench for muldiv_unit_p: cycle compare against an arithmetic model plus directed literal expectations.
module tb_muldiv_unit_p;

  localparam int W    = 32;
  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start, cancel;
  logic [3:0]    op;
  logic [W-1:0]  rs, rt;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int pass_cnt = 0;
  int check_cnt = 0;
  int busy_seen = 0;
  int done_seen = 0;

  // Model state: architectural HI/LO, pending result and cycles left until commit.
  logic [W-1:0]   m_hi = '0, m_lo = '0;
  logic [2*W-1:0] m_pend = '0;
  int             m_left = 0;
  logic           m_done = 1'b0;

  muldiv_unit_p #(.WIDTH(W), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] model_result(input logic [3:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] hl);
    longint    sa, sb;
    logic [63:0] ps, pu;
    int        ia, ib, q, r;
    sa = $signed(a);
    sb = $signed(b);
    ps = sa * sb;
    pu = {32'b0, a} * {32'b0, b};
    ia = a;
    ib = b;
    case (o)
      4'd0: return ps;
      4'd1: return pu;
      4'd6: return hl + ps;
      4'd7: return hl + pu;
      4'd8: return hl - ps;
      4'd9: return hl - pu;
      4'd2: begin
        if (b == 0) return hl;
        if (ia == int'(32'h8000_0000) && ib == -1) begin
          q = ia;
          r = 0;
        end else begin
          q = ia / ib;
          r = ia % ib;
        end
        return {r, q};
      end
      4'd3: begin
        if (b == 0) return hl;
        return {a % b, a / b};
      end
      default: return hl;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (cancel) m_left = 0;
        else if (m_left == 1) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
          m_left = 0;
        end else m_left--;
      end else if (start && !cancel) begin
        if (op == 4'd4) m_hi = rs;
        else if (op == 4'd5) m_lo = rs;
        else if (op <= 4'd9) begin
          m_pend = model_result(op, rs, rt, {m_hi, m_lo});
          m_left = (op == 4'd2 || op == 4'd3) ? DIVC : MULC;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("cyc_busy", 64'(busy), 64'(m_left > 0));
      check("cyc_done", 64'(done), 64'(m_done));
      check("cyc_hi", 64'(hi), 64'(m_hi));
      check("cyc_lo", 64'(lo), 64'(m_lo));
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_timed(input string name, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input int n, input logic [31:0] ehi,
                           input logic [31:0] elo);
    busy_seen = 0;
    done_seen = 0;
    issue(o, a, b);
    repeat (n + 2) @(posedge clk);
    #1;
    check({name, "_busycycles"}, 64'(busy_seen), 64'(n));
    check({name, "_donepulses"}, 64'(done_seen), 64'd1);
    check({name, "_hi"}, 64'(hi), 64'(ehi));
    check({name, "_lo"}, 64'(lo), 64'(elo));
    check({name, "_model_hi"}, 64'(m_hi), 64'(ehi));
    check({name, "_model_lo"}, 64'(m_lo), 64'(elo));
  endtask

  initial begin
    start = 1'b0; cancel = 1'b0; op = '0; rs = '0; rt = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);

    run_timed("mult", 4'd0, 32'hFFFF_FFFF, 32'h2, MULC, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_timed("multu", 4'd1, 32'hFFFF_FFFF, 32'h2, MULC, 32'h0000_0001, 32'hFFFF_FFFE);
    run_timed("div_neg", 4'd2, 32'hFFFF_FFF9, 32'h2, DIVC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_timed("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIVC, 32'h0, 32'h8000_0000);

    issue(4'd4, 32'd5, 32'd0);
    issue(4'd5, 32'd3, 32'd0);
    @(negedge clk);
    check("mt_hi", 64'(hi), 64'd5);
    check("mt_lo", 64'(lo), 64'd3);
    run_timed("maddu", 4'd7, 32'd2, 32'd4, MULC, 32'd5, 32'd11);
    run_timed("msub", 4'd8, 32'd1, 32'd12, MULC, 32'd4, 32'hFFFF_FFFF);

    // Divide by zero with a stray start in the middle of the busy window.
    issue(4'd4, 32'hA, 32'd0);
    issue(4'd5, 32'hB, 32'd0);
    busy_seen = 0;
    done_seen = 0;
    issue(4'd3, 32'd100, 32'd0);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; op = 4'd0; rs = 32'd3; rt = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("divz_busycycles", 64'(busy_seen), 64'(DIVC));
    check("divz_donepulses", 64'(done_seen), 64'd1);
    check("divz_hi", 64'(hi), 64'hA);
    check("divz_lo", 64'(lo), 64'hB);

    // Cancel during the third busy cycle.
    busy_seen = 0;
    done_seen = 0;
    issue(4'd0, 32'd7, 32'd9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_busy_low", 64'(busy), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check("cancel_busycycles", 64'(busy_seen), 64'd3);
    check("cancel_nodone", 64'(done_seen), 64'd0);
    check("cancel_hi", 64'(hi), 64'hA);
    check("cancel_lo", 64'(lo), 64'hB);

    // start and cancel together: cancel wins even for mthi.
    @(posedge clk); #1;
    start = 1'b1; op = 4'd4; rs = 32'd77; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check("startcancel_hi", 64'(hi), 64'hA);

    issue(4'd12, 32'd55, 32'd55);
    @(negedge clk);
    check("noop_busy", 64'(busy), 64'd0);
    check("noop_hi", 64'(hi), 64'hA);
    check("noop_lo", 64'(lo), 64'hB);

    // Asynchronous reset in the middle of a divide.
    issue(4'd2, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;

    run_timed("divu", 4'd3, 32'd100, 32'd7, DIVC, 32'd2, 32'd14);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
